rf_wb_ctrl: RTL
===============

# rf_wb_ctrl

Write-back controller that owns the integer register file's single write port. It merges single-cycle ALU results with buffered multi-cycle load results into one registered write per cycle. It tracks outstanding load destinations in a busy scoreboard for issue-stage hazard checks. It sits between the execute/LSU stages and the register file's `reg_wen`/`reg_waddr`/`reg_wdata` inputs.

## Interface

Reset is decided as follows: one clock `clk`; reset `rst` is synchronous and active-high.

**Parameters**
- `DW`, default `CPU_WIDTH`: data width.
- `AW`, default `REG_ADDR_WIDTH`: register address width.
- `DEPTH`, default 2: LSU result FIFO depth. Legal range 1–8.

**Ports**
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `alu_valid` in 1: ALU result present this cycle.
- `alu_rd` in AW: ALU destination register.
- `alu_data` in DW: ALU result.
- `alu_stall` out 1: ALU result not accepted this cycle. The ALU source holds its result.
- `lsu_valid` in 1: load result offered.
- `lsu_ready` out 1: FIFO can accept.
- `lsu_rd` in AW: load destination register.
- `lsu_data` in DW: load data.
- `ld_issue_valid` in 1: a load was issued.
- `ld_issue_rd` in AW: destination of the issued load.
- `busy` out 2^AW: scoreboard. Bit i is set while a load to xi is outstanding.
- `reg_wen` out 1: register file write enable.
- `reg_waddr` out AW: register file write address.
- `reg_wdata` out DW: register file write data.
- `reg1_raddr`, `reg2_raddr` in AW: decode read addresses, used for forwarding.
- `fwd1_hit`, `fwd2_hit` out 1: forwarding hit.
- `fwd1_data`, `fwd2_data` out DW: forwarded data.

## Operation

**Acceptance**
- LSU push happens when `lsu_valid && lsu_ready`.
- `lsu_ready = (count != DEPTH)`. There is no same-cycle push-through when full.

**Arbitration (one write per cycle)**
- `full` is `count == DEPTH`.
- If `full`: pop the FIFO head and assert `alu_stall=1`. `alu_valid` is ignored that cycle.
- Else if `alu_valid`: take the ALU result, with `alu_stall=0`.
- Else if `count != 0`: pop the FIFO head.
- Otherwise there is no write.

**FIFO**
- FIFO ordering is strict.
- Push and pop in the same cycle leave `count` unchanged.
- Pointers wrap modulo DEPTH.

**Write port**
- The selected write is registered into `reg_wen`, `reg_waddr`, `reg_wdata`.
- Any write whose rd is x0 is consumed but drives `reg_wen=0`. `reg_waddr` and `reg_wdata` still update.

**Scoreboard**
- `ld_issue_valid` with rd≠0 sets `busy[rd]`.
- A popped LSU entry clears `busy[rd]` in the cycle it is popped.
- Simultaneous set and clear of the same rd: set wins.
- ALU writes never touch `busy`.
- `busy[0]` is always 0.

**Reset**
- Reset to 0: `count`, pointers, `busy`, `reg_wen`, `reg_waddr`, `reg_wdata`.
- `lsu_ready` is 1 after reset.
- `alu_stall` is 0 after reset.
- FIFO contents are dropped.
- Reset asserted mid-operation discards all queued loads, including a same-cycle push.

## Timing

**Latencies**
- ALU accepted in cycle N → `reg_wen=1` in cycle N+1. The register file commits at the end of N+1.
- LSU pushed in cycle N → earliest pop in N+1 → `reg_wen` in N+2.
- Sustained `alu_valid` delays LSU writes until the FIFO fills. The stall then forces one LSU write.

**Combinational outputs**
- `alu_stall` and `lsu_ready` are combinational from `count`; they do not depend on inputs.
- `busy` is registered and visible the cycle after the set or clear.

## Configuration

Macro: `RF_WB_FWD_EN`.

- **Defined:** `fwdK_hit = reg_wen && (reg_waddr == regK_raddr) && (regK_raddr != 0)` and `fwdK_data = reg_wdata`. Both are combinational. Decode uses them to see the value committing this cycle.
- **Undefined:** the ports remain, and all `fwd*` outputs are tied to 0.

## Structure

**Shared constants**
- `CPU_WIDTH`, `REG_ADDR_WIDTH` and `REG_DATA_DEPTH` come from `rvseed_defines.v`.
- Add `WB_FIFO_DEPTH` (default 2) there.
- No new typedefs.

**Sub-module**
- One sub-module, `wb_fifo`: a parameterised synchronous FIFO (DW+AW wide).
- It has push/pop, `count`, `full` and `empty`.
- The arbiter, scoreboard and output register live in `rf_wb_ctrl`.

## Test plan

1. **ALU only.** `alu_valid=1`, rd=5, data=0x1234 in cycle 3 → `reg_wen=1`, `reg_waddr=5`, `reg_wdata=0x1234` in cycle 4. `alu_stall=0` throughout.
2. **x0 suppression.** ALU rd=0, data=0xFFFF → `reg_wen=0` next cycle. An LSU push with rd=0 is popped and also gives `reg_wen=0`.
3. **Backpressure and forced drain** (DEPTH=2).
   - Setup: `ld_issue` x7 and x9; push loads x7=0xA, x9=0xB while `alu_valid` is held high.
   - `lsu_ready` goes to 0 after the 2nd push.
   - The next cycle has `alu_stall=1` and x7=0xA is written.
   - `busy[7]` clears; `busy[9]` stays 1 until its pop.
4. **Set/clear collision.** `ld_issue_rd=7` in the same cycle that x7's load pops → `busy[7]` remains 1.
5. **Reset mid-operation.** With FIFO count=2 and `busy` bits set, assert `rst` for 1 cycle.
   - Next cycle: `reg_wen=0`, `busy=0`, `lsu_ready=1`.
   - No queued write ever appears.
6. **Forwarding (`RF_WB_FWD_EN`).** `reg_wen=1`, `reg_waddr=3`, data 0x55, with `reg1_raddr=3` and `reg2_raddr=4` → `fwd1_hit=1`, `fwd1_data=0x55`, `fwd2_hit=0`. Without the macro, all `fwd*` are 0.

Source files
------------

// File: rtl/rf_wb_ctrl_pkg.sv
// Shared constants for the write-back controller slice.
// These mirror the CPU-wide constants from rvseed_defines.v so that
// SystemVerilog files can pick them up through a package import.
package rf_wb_ctrl_pkg;

    localparam int CPU_WIDTH      = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_DEPTH = 32;
    localparam int WB_FIFO_DEPTH  = 2;

endpackage

// File: rtl/rf_wb_ctrl_wb_fifo.sv
// wb_fifo: small synchronous FIFO that buffers load results waiting for
// the register-file write port. Push is ignored when full and pop is
// ignored when empty, so callers may drive them from plain handshakes.
module wb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 wdata,
    output logic [W-1:0]                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer advance with wrap at DEPTH and occupancy bookkeeping
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control state; reset drops everything queued, including a same-cycle push
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless once pointers are reset
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/rf_wb_ctrl.sv
// rf_wb_ctrl: owns the register file's single write port. Merges ALU
// results with buffered load results (one registered write per cycle),
// and keeps a busy scoreboard of outstanding load destinations.
// Optional macro RF_WB_FWD_EN enables write-port forwarding to decode;
// without it the fwd* outputs are tied to zero.
module rf_wb_ctrl
    import rf_wb_ctrl_pkg::*;
#(
    parameter int DW    = CPU_WIDTH,
    parameter int AW    = REG_ADDR_WIDTH,
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [AW-1:0]        alu_rd,
    input  logic [DW-1:0]        alu_data,
    output logic                 alu_stall,
    input  logic                 lsu_valid,
    output logic                 lsu_ready,
    input  logic [AW-1:0]        lsu_rd,
    input  logic [DW-1:0]        lsu_data,
    input  logic                 ld_issue_valid,
    input  logic [AW-1:0]        ld_issue_rd,
    output logic [(1<<AW)-1:0]   busy,
    output logic                 reg_wen,
    output logic [AW-1:0]        reg_waddr,
    output logic [DW-1:0]        reg_wdata,
    input  logic [AW-1:0]        reg1_raddr,
    input  logic [AW-1:0]        reg2_raddr,
    output logic                 fwd1_hit,
    output logic                 fwd2_hit,
    output logic [DW-1:0]        fwd1_data,
    output logic [DW-1:0]        fwd2_data
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [CW-1:0]       fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic [AW+DW-1:0]    fifo_head;
    logic [AW-1:0]       head_rd;
    logic [DW-1:0]       head_data;
    logic                lsu_push;
    logic                lsu_pop;
    logic                take_alu;
    logic                wr_valid;
    logic [AW-1:0]       wr_rd;
    logic [DW-1:0]       wr_data;

    logic                reg_wen_q, reg_wen_d;
    logic [AW-1:0]       reg_waddr_q, reg_waddr_d;
    logic [DW-1:0]       reg_wdata_q, reg_wdata_d;
    logic [(1<<AW)-1:0]  busy_q, busy_d;

    assign lsu_ready = (fifo_count != DEPTH_CNT);
    assign alu_stall = fifo_full;
    assign lsu_push  = lsu_valid && lsu_ready;
    assign head_rd   = fifo_head[AW+DW-1:DW];
    assign head_data = fifo_head[DW-1:0];

    wb_fifo #(
        .W     (AW + DW),
        .DEPTH (DEPTH)
    ) u_wb_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (lsu_push),
        .pop   (lsu_pop),
        .wdata ({lsu_rd, lsu_data}),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Arbiter: a full FIFO forces a load write, otherwise ALU wins, else drain
    always_comb begin
        lsu_pop  = 1'b0;
        take_alu = 1'b0;
        wr_valid = 1'b0;
        wr_rd    = '0;
        wr_data  = '0;
        if (fifo_full) begin
            lsu_pop  = 1'b1;
            wr_valid = 1'b1;
            wr_rd    = head_rd;
            wr_data  = head_data;
        end else if (alu_valid) begin
            take_alu = 1'b1;
            wr_valid = 1'b1;
            wr_rd    = alu_rd;
            wr_data  = alu_data;
        end else if (!fifo_empty) begin
            lsu_pop  = 1'b1;
            wr_valid = 1'b1;
            wr_rd    = head_rd;
            wr_data  = head_data;
        end
    end

    // Next write-port value; x0 writes still update address/data but not enable
    always_comb begin
        reg_wen_d   = wr_valid && (wr_rd != '0);
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        if (wr_valid) begin
            reg_waddr_d = wr_rd;
            reg_wdata_d = wr_data;
        end
    end

    // Scoreboard update: clear on load pop, then set on issue so set wins
    always_comb begin
        busy_d = busy_q;
        if (lsu_pop) begin
            busy_d[head_rd] = 1'b0;
        end
        if (ld_issue_valid) begin
            busy_d[ld_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Registered write port and scoreboard
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_wen_q   <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            busy_q      <= '0;
        end else begin
            reg_wen_q   <= reg_wen_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign reg_wen   = reg_wen_q;
    assign reg_waddr = reg_waddr_q;
    assign reg_wdata = reg_wdata_q;
    assign busy      = busy_q;

`ifdef RF_WB_FWD_EN
    assign fwd1_hit  = reg_wen_q && (reg_waddr_q == reg1_raddr) && (reg1_raddr != '0);
    assign fwd2_hit  = reg_wen_q && (reg_waddr_q == reg2_raddr) && (reg2_raddr != '0);
    assign fwd1_data = reg_wdata_q;
    assign fwd2_data = reg_wdata_q;
`else
    logic unused_raddr;
    assign unused_raddr = ^{reg1_raddr, reg2_raddr, take_alu};
    assign fwd1_hit  = 1'b0;
    assign fwd2_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_data = '0;
`endif

endmodule
